// File: rtl/data_sram_like_slave.sv
// Responder for the CPU data-side SRAM-like bus: in-order request queue, fixed-latency responses, word memory.
// Optional RANDOM_DELAY_EN inserts pseudo-random accept stalls and latency stretches from a 16-bit LFSR.
module data_sram_like_slave #(
  parameter int ADDR_W      = 12,
  parameter int OUTSTANDING = 2,
  parameter int RESP_LAT    = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int LAT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RESP_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_WAIT,
    ST_RESP
  } state_t;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  logic              q_wr    [OUTSTANDING];
  logic [ADDR_W-1:0] q_idx   [OUTSTANDING];
  logic [3:0]        q_wstrb [OUTSTANDING];
  logic [31:0]       q_wdata [OUTSTANDING];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [LAT_W-1:0]  lat_cnt;
  logic [LAT_W-1:0]  lat_cnt_next;
  state_t            state;
  state_t            state_next;

  logic              push;
  logic              pop;
  logic              head_load;
  logic              stall_accept;
  logic              freeze;

  logic              head_wr;
  logic [ADDR_W-1:0] head_idx;
  logic [3:0]        head_wstrb;
  logic [31:0]       head_wdata;

  logic              unused_bits;

  assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

`ifdef RANDOM_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall_accept = lfsr[0];
  assign freeze       = lfsr[1];
`else
  assign stall_accept = 1'b0;
  assign freeze       = 1'b0;
`endif

  // No bypass: a full queue refuses even when the head pops this cycle.
  assign data_sram_addr_ok = data_sram_req & resetn & ~stall_accept & (count < MAX_CNT);
  assign push              = data_sram_req & data_sram_addr_ok;
  assign pop               = (state == ST_RESP);

  assign head_wr    = q_wr[rd_ptr];
  assign head_idx   = q_idx[rd_ptr];
  assign head_wstrb = q_wstrb[rd_ptr];
  assign head_wdata = q_wdata[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      q_wr[wr_ptr]    <= data_sram_wr;
      q_idx[wr_ptr]   <= data_sram_addr[ADDR_W+1:2];
      q_wstrb[wr_ptr] <= data_sram_wstrb;
      q_wdata[wr_ptr] <= data_sram_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + ONE_CNT;
      end else if (!push && pop) begin
        count <= count - ONE_CNT;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_EMPTY;
      lat_cnt <= '0;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_cnt_next;
    end
  end

  // A new head (first push into an empty queue, or the entry behind a pop) restarts the latency count.
  always_comb begin
    state_next   = state;
    lat_cnt_next = lat_cnt;
    head_load    = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (push) begin
          head_load = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!freeze) begin
          lat_cnt_next = lat_cnt - LAT_ONE;
          if (lat_cnt == LAT_ONE) begin
            state_next = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (push || (count > ONE_CNT)) begin
          head_load = 1'b1;
        end else begin
          state_next = ST_EMPTY;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
    if (head_load) begin
      lat_cnt_next = LAT_LOAD;
      state_next   = (RESP_LAT == 1) ? ST_RESP : ST_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (pop && head_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (head_wstrb[b]) begin
          mem[head_idx][8*b +: 8] <= head_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read is taken during the response cycle, so a load behind a store to the same word sees it.
  assign data_sram_data_ok = (state == ST_RESP);
  assign data_sram_rdata   = ((state == ST_RESP) && !head_wr) ? mem[head_idx] : 32'h0;

endmodule

// File: tb/tb_data_sram_like_slave.sv
// Self-checking bench: a RESP_LAT=1 instance driven from a vector table, and a RESP_LAT=4 instance
// exercised with hand-written cycle sequences for back-pressure and mid-wait reset.
module tb_data_sram_like_slave;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  logic        a_req, a_wr;
  logic [1:0]  a_size;
  logic [3:0]  a_wstrb;
  logic [31:0] a_addr, a_wdata;
  logic        a_addr_ok, a_data_ok;
  logic [31:0] a_rdata;

  logic        b_req, b_wr;
  logic [1:0]  b_size;
  logic [3:0]  b_wstrb;
  logic [31:0] b_addr, b_wdata;
  logic        b_addr_ok, b_data_ok;
  logic [31:0] b_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_addr_ok;
    logic        exp_data_ok;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  data_sram_like_slave #(.ADDR_W(12), .OUTSTANDING(2), .RESP_LAT(1)) dut_a (
    .clk(clk), .resetn(resetn),
    .data_sram_req(a_req), .data_sram_wr(a_wr), .data_sram_size(a_size),
    .data_sram_wstrb(a_wstrb), .data_sram_addr(a_addr), .data_sram_wdata(a_wdata),
    .data_sram_addr_ok(a_addr_ok), .data_sram_data_ok(a_data_ok), .data_sram_rdata(a_rdata)
  );

  data_sram_like_slave #(.ADDR_W(12), .OUTSTANDING(2), .RESP_LAT(4)) dut_b (
    .clk(clk), .resetn(resetn),
    .data_sram_req(b_req), .data_sram_wr(b_wr), .data_sram_size(b_size),
    .data_sram_wstrb(b_wstrb), .data_sram_addr(b_addr), .data_sram_wdata(b_wdata),
    .data_sram_addr_ok(b_addr_ok), .data_sram_data_ok(b_data_ok), .data_sram_rdata(b_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    a_req   = v.req;
    a_wr    = v.wr;
    a_wstrb = v.wstrb;
    a_addr  = v.addr;
    a_wdata = v.wdata;
    a_size  = 2'd2;
    #1;
    checkOutput({v.name, ".addr_ok"}, {31'b0, a_addr_ok}, {31'b0, v.exp_addr_ok});
    checkOutput({v.name, ".data_ok"}, {31'b0, a_data_ok}, {31'b0, v.exp_data_ok});
    checkOutput({v.name, ".rdata"}, a_rdata, v.exp_rdata);
  endtask

  task automatic driveB(input logic req, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    b_req   = req;
    b_wr    = wr;
    b_wstrb = 4'hF;
    b_addr  = addr;
    b_wdata = wdata;
    b_size  = 2'd2;
    #1;
  endtask

  // Full bounded transaction on instance B; returns at the data_ok cycle.
  task automatic bTxn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic ok);
    int n;
    ok = 1'b0;
    rdata = '0;
    driveB(1'b1, wr, addr, wdata);
    n = 0;
    while (!b_addr_ok && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (b_addr_ok) begin
      driveB(1'b0, 1'b0, 32'h0, 32'h0);
      n = 0;
      while (!b_data_ok && n < 20) begin
        @(negedge clk); #1; n++;
      end
      ok = b_data_ok;
      rdata = b_rdata;
    end else begin
      b_req = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        ok;
    logic        exp_aok, exp_dok;
    logic [31:0] exp_rd;
    int          c;

    a_req = 0; a_wr = 0; a_size = 0; a_wstrb = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_wr = 0; b_size = 0; b_wstrb = 0; b_addr = 0; b_wdata = 0;

    vecs.push_back('{"idle0",      1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0});
    vecs.push_back('{"st100",      1'b1, 1'b1, 4'hF, 32'h100,  32'h12345678, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{"ld100",      1'b1, 1'b0, 4'h0, 32'h100,  32'h0,        1'b1, 1'b1, 32'h0});
    vecs.push_back('{"stb101",     1'b1, 1'b1, 4'h2, 32'h101,  32'hAAAAAAAA, 1'b1, 1'b1, 32'h12345678});
    vecs.push_back('{"ld100b",     1'b1, 1'b0, 4'h0, 32'h100,  32'h0,        1'b1, 1'b1, 32'h0});
    vecs.push_back('{"mergeresp",  1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h1234AA78});
    vecs.push_back('{"st0",        1'b1, 1'b1, 4'hF, 32'h0,    32'h11,       1'b1, 1'b0, 32'h0});
    vecs.push_back('{"st4",        1'b1, 1'b1, 4'hF, 32'h4,    32'h22,       1'b1, 1'b1, 32'h0});
    vecs.push_back('{"st8",        1'b1, 1'b1, 4'hF, 32'h8,    32'h33,       1'b1, 1'b1, 32'h0});
    vecs.push_back('{"ld0",        1'b1, 1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h0});
    vecs.push_back('{"ld4",        1'b1, 1'b0, 4'h0, 32'h4,    32'h0,        1'b1, 1'b1, 32'h11});
    vecs.push_back('{"ld8",        1'b1, 1'b0, 4'h0, 32'h8,    32'h0,        1'b1, 1'b1, 32'h22});
    vecs.push_back('{"b2b_last",   1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h33});
    vecs.push_back('{"b2b_done",   1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0});
    vecs.push_back('{"st200",      1'b1, 1'b1, 4'hF, 32'h200,  32'hCAFEF00D, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{"st200_nostb",1'b1, 1'b1, 4'h0, 32'h200,  32'hFFFFFFFF, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{"ld200",      1'b1, 1'b0, 4'h0, 32'h200,  32'h0,        1'b1, 1'b1, 32'h0});
    vecs.push_back('{"ld200resp",  1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b1, 32'hCAFEF00D});
    vecs.push_back('{"idle1",      1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0});
    vecs.push_back('{"ldalias",    1'b1, 1'b0, 4'h0, 32'h4100, 32'h0,        1'b1, 1'b0, 32'h0});
    vecs.push_back('{"aliasresp",  1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h1234AA78});
    vecs.push_back('{"ldunalign",  1'b1, 1'b0, 4'h0, 32'h103,  32'h0,        1'b1, 1'b0, 32'h0});
    vecs.push_back('{"unalresp",   1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h1234AA78});

    // Power-on reset: outputs quiet and requests refused while held.
    repeat (2) @(negedge clk);
    a_req = 1'b1;
    #1;
    checkOutput("por.addr_ok", {31'b0, a_addr_ok}, 32'h0);
    checkOutput("por.data_ok", {31'b0, a_data_ok}, 32'h0);
    checkOutput("por.rdata", a_rdata, 32'h0);
    @(negedge clk);
    a_req = 1'b0;
    resetn = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
    end
    @(negedge clk);
    a_req = 1'b0;

    // Preload instance B.
    bTxn(1'b1, 32'h10, 32'hA1, rd, ok);
    checkOutput("pre10.ok", {31'b0, ok}, 32'h1);
    bTxn(1'b1, 32'h14, 32'hB2, rd, ok);
    checkOutput("pre14.ok", {31'b0, ok}, 32'h1);
    bTxn(1'b1, 32'h18, 32'hC3, rd, ok);
    checkOutput("pre18.ok", {31'b0, ok}, 32'h1);
    checkOutput("pre18.rdata", rd, 32'h0);

    // Full queue: third load refused until the cycle after the first response.
    for (int t = 0; t < 14; t++) begin
      if (t == 0)      driveB(1'b1, 1'b0, 32'h10, 32'h0);
      else if (t == 1) driveB(1'b1, 1'b0, 32'h14, 32'h0);
      else if (t <= 5) driveB(1'b1, 1'b0, 32'h18, 32'h0);
      else             driveB(1'b0, 1'b0, 32'h0, 32'h0);
      exp_aok = (t == 0) || (t == 1) || (t == 5);
      exp_dok = (t == 4) || (t == 8) || (t == 12);
      exp_rd  = (t == 4) ? 32'hA1 : (t == 8) ? 32'hB2 : (t == 12) ? 32'hC3 : 32'h0;
      checkOutput($sformatf("full.t%0d.addr_ok", t), {31'b0, b_addr_ok}, {31'b0, exp_aok});
      checkOutput($sformatf("full.t%0d.data_ok", t), {31'b0, b_data_ok}, {31'b0, exp_dok});
      checkOutput($sformatf("full.t%0d.rdata", t), b_rdata, exp_rd);
    end

    // Reset with two loads queued mid-wait: nothing may come back afterwards.
    driveB(1'b1, 1'b0, 32'h10, 32'h0);
    driveB(1'b1, 1'b0, 32'h14, 32'h0);
    @(negedge clk);
    b_req = 1'b0;
    resetn = 1'b0;
    #1;
    checkOutput("rst.data_ok", {31'b0, b_data_ok}, 32'h0);
    checkOutput("rst.rdata", b_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    b_req = 1'b1;
    #1;
    checkOutput("rst.addr_ok", {31'b0, b_addr_ok}, 32'h0);
    checkOutput("rst.data_ok2", {31'b0, b_data_ok}, 32'h0);
    @(negedge clk);
    b_req = 1'b0;
    resetn = 1'b1;
    #1;
    for (int t = 0; t < 8; t++) begin
      checkOutput($sformatf("postrst.t%0d.data_ok", t), {31'b0, b_data_ok}, 32'h0);
      @(negedge clk); #1;
    end
    driveB(1'b1, 1'b0, 32'h18, 32'h0);
    checkOutput("postrst.addr_ok", {31'b0, b_addr_ok}, 32'h1);
    c = 0;
    for (int t = 1; t <= 5; t++) begin
      driveB(1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput($sformatf("postrst.c%0d.data_ok", t), {31'b0, b_data_ok}, {31'b0, (t == 4)});
      if (t == 4) checkOutput("postrst.rdata", b_rdata, 32'hC3);
      c++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
